// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and load/store masters.
// Define ARB_ROUND_ROBIN_EN for alternating priority on contention; otherwise data always wins.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req_i,
  input  logic [ADDR_W-1:0]   inst_addr_i,
  output logic [DATA_W-1:0]   inst_rdata_o,
  output logic                inst_ack_o,
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  input  logic [DATA_W/8-1:0] data_sel_i,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                data_ack_o,
  output logic                mem_ce_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_sel_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                stallreq_o
);
  localparam int SEL_W = DATA_W / 8;
  localparam logic [3:0] CNT_LAST = 4'(LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q;
  logic                own_q;
  logic [3:0]          cnt_q;
  logic                mem_ce_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [SEL_W-1:0]    mem_sel_q;
  logic                inst_ack_q, data_ack_q;
  logic [DATA_W-1:0]   inst_rdata_q, data_rdata_q;
  logic                own_d;

  // Owner chosen in IDLE: 1 = data master, 0 = fetch master.
`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;
  assign own_d = (inst_req_i && data_req_i) ? ~last_q : data_req_i;
`else
  assign own_d = data_req_i;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      own_q        <= 1'b0;
      cnt_q        <= 4'd0;
      mem_ce_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_sel_q    <= '0;
      inst_ack_q   <= 1'b0;
      data_ack_q   <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (inst_req_i || data_req_i) begin
            own_q    <= own_d;
            cnt_q    <= 4'd0;
            mem_ce_q <= 1'b1;
            state_q  <= ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
            last_q   <= own_d;
`endif
            if (own_d) begin
              mem_addr_q  <= data_addr_i;
              mem_we_q    <= data_we_i;
              mem_wdata_q <= data_wdata_i;
              mem_sel_q   <= data_sel_i;
            end else begin
              mem_addr_q  <= inst_addr_i;
              mem_we_q    <= 1'b0;
              mem_sel_q   <= '1;
            end
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == CNT_LAST) begin
            mem_ce_q <= 1'b0;
            mem_we_q <= 1'b0;
            state_q  <= DONE;
            // Stores leave the load data register untouched.
            if (own_q) begin
              data_ack_q <= 1'b1;
              if (!mem_we_q) data_rdata_q <= mem_rdata_i;
            end else begin
              inst_ack_q   <= 1'b1;
              inst_rdata_q <= mem_rdata_i;
            end
          end
        end
        DONE: begin
          inst_ack_q <= 1'b0;
          data_ack_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_ce_o     = mem_ce_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_sel_o    = mem_sel_q;
  assign inst_ack_o   = inst_ack_q;
  assign data_ack_o   = data_ack_q;
  assign inst_rdata_o = inst_rdata_q;
  assign data_rdata_o = data_rdata_q;
  assign stallreq_o   = (inst_req_i & ~inst_ack_q) | (data_req_i & ~data_ack_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: one LAT=1 and one LAT=3 instance on a shared memory model.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        en1 = 1'b0, en3 = 1'b0;
  logic        inst_req = 1'b0, data_req = 1'b0, data_we = 1'b0;
  logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0;
  logic [3:0]  data_sel = '0;

  logic [31:0] irdata1, drdata1, addr1, wdata1, mrd1;
  logic [31:0] irdata3, drdata3, addr3, wdata3, mrd3;
  logic        iack1, dack1, ce1, we1, stall1;
  logic        iack3, dack3, ce3, we3, stall3;
  logic [3:0]  sel1, sel3;

  int cyc = 0;
  int n_cmp = 0, n_err = 0;

  typedef struct { bit is_data; logic [31:0] rdata; int ack_cyc; } exp_t;
  exp_t sbq[$];

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .inst_req_i(inst_req & en1), .inst_addr_i(inst_addr), .inst_rdata_o(irdata1), .inst_ack_o(iack1),
    .data_req_i(data_req & en1), .data_we_i(data_we), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_sel_i(data_sel), .data_rdata_o(drdata1), .data_ack_o(dack1),
    .mem_ce_o(ce1), .mem_we_o(we1), .mem_addr_o(addr1), .mem_wdata_o(wdata1), .mem_sel_o(sel1),
    .mem_rdata_i(mrd1), .stallreq_o(stall1));

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(3)) u3 (
    .clk(clk), .rst(rst),
    .inst_req_i(inst_req & en3), .inst_addr_i(inst_addr), .inst_rdata_o(irdata3), .inst_ack_o(iack3),
    .data_req_i(data_req & en3), .data_we_i(data_we), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_sel_i(data_sel), .data_rdata_o(drdata3), .data_ack_o(dack3),
    .mem_ce_o(ce3), .mem_we_o(we3), .mem_addr_o(addr3), .mem_wdata_o(wdata3), .mem_sel_o(sel3),
    .mem_rdata_i(mrd3), .stallreq_o(stall3));

  // Memory model: read data is only valid in the LAT-th enabled cycle, garbage otherwise.
  logic [31:0] mem [0:255];
  int  ccnt1 = 0, ccnt3 = 0;
  bit  init_done = 1'b0;
  assign mrd1 = (ce1 && ccnt1 == 0) ? mem[addr1[9:2]] : 32'hBAD0_0001;
  assign mrd3 = (ce3 && ccnt3 == 2) ? mem[addr3[9:2]] : 32'hBAD0_0003;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    ccnt1 <= ce1 ? ccnt1 + 1 : 0;
    ccnt3 <= ce3 ? ccnt3 + 1 : 0;
    if (!init_done) begin
      mem[1]    <= 32'h3401_0100;
      init_done <= 1'b1;
    end
    for (int b = 0; b < 4; b++) begin
      if (ce1 && we1 && sel1[b]) mem[addr1[9:2]][8*b +: 8] <= wdata1[8*b +: 8];
      if (ce3 && we3 && sel3[b]) mem[addr3[9:2]][8*b +: 8] <= wdata3[8*b +: 8];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Steps negedges until the chosen ack appears; reports what was seen (no judging here).
  task automatic run_until_ack(input bit on3, input bit is_data, output int at,
                               output logic [31:0] rd, output int nce, output logic [31:0] a,
                               output logic w, output logic [3:0] s, output logic ack_after);
    logic ce, ack;
    at = -1; rd = '0; nce = 0; a = '0; w = 1'b0; s = '0; ack_after = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      ce = on3 ? ce3 : ce1;
      if (ce) begin
        if (nce == 0) begin
          a = on3 ? addr3 : addr1;
          w = on3 ? we3 : we1;
          s = on3 ? sel3 : sel1;
        end
        nce++;
      end
      ack = on3 ? (is_data ? dack3 : iack3) : (is_data ? dack1 : iack1);
      if (ack) begin
        at = cyc;
        rd = on3 ? (is_data ? drdata3 : irdata3) : (is_data ? drdata1 : irdata1);
        if (is_data) data_req = 1'b0; else inst_req = 1'b0;
        @(negedge clk);
        ack_after = on3 ? (is_data ? dack3 : iack3) : (is_data ? dack1 : iack1);
        break;
      end
    end
  endtask

  task automatic test_reset();
    en1 = 1'b1; en3 = 1'b1; rst = 1'b0; inst_req = 1'b1; data_req = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (ce1 !== 1'b0)     begin n_err++; $display("FAIL reset_ce1 got %b want 0", ce1); end
    n_cmp++; if (ce3 !== 1'b0)     begin n_err++; $display("FAIL reset_ce3 got %b want 0", ce3); end
    n_cmp++; if ({iack1, dack1} !== 2'b00) begin n_err++; $display("FAIL reset_ack1 got %b want 00", {iack1, dack1}); end
    n_cmp++; if ({iack3, dack3} !== 2'b00) begin n_err++; $display("FAIL reset_ack3 got %b want 00", {iack3, dack3}); end
    n_cmp++; if (irdata1 !== 32'h0) begin n_err++; $display("FAIL reset_irdata1 got %h want 0", irdata1); end
    n_cmp++; if (drdata1 !== 32'h0) begin n_err++; $display("FAIL reset_drdata1 got %h want 0", drdata1); end
    n_cmp++; if (irdata3 !== 32'h0) begin n_err++; $display("FAIL reset_irdata3 got %h want 0", irdata3); end
    n_cmp++; if (drdata3 !== 32'h0) begin n_err++; $display("FAIL reset_drdata3 got %h want 0", drdata3); end
    n_cmp++; if (stall1 !== 1'b1)  begin n_err++; $display("FAIL reset_stall1 got %b want 1", stall1); end
    n_cmp++; if (stall3 !== 1'b1)  begin n_err++; $display("FAIL reset_stall3 got %b want 1", stall3); end
    rst = 1'b1; inst_req = 1'b0; data_req = 1'b0;
    @(negedge clk);
    n_cmp++; if ({ce1, ce3, stall1} !== 3'b000) begin n_err++; $display("FAIL post_reset_idle got %b want 000", {ce1, ce3, stall1}); end
  endtask

  task automatic test_single_fetch();
    int at, nce, c; logic [31:0] rd, a; logic w, aa; logic [3:0] s; exp_t e;
    en1 = 1'b1; en3 = 1'b0;
    inst_addr = 32'h0000_0004; inst_req = 1'b1; c = cyc;
    sbq.push_back('{1'b0, 32'h3401_0100, c + 2});
    run_until_ack(1'b0, 1'b0, at, rd, nce, a, w, s, aa);
    e = sbq.pop_front();
    n_cmp++; if (at !== e.ack_cyc)  begin n_err++; $display("FAIL fetch_ack_cycle got %0d want %0d", at, e.ack_cyc); end
    n_cmp++; if (rd !== e.rdata)    begin n_err++; $display("FAIL fetch_rdata got %h want %h", rd, e.rdata); end
    n_cmp++; if (nce !== 1)         begin n_err++; $display("FAIL fetch_ce_cycles got %0d want 1", nce); end
    n_cmp++; if (a !== 32'h4)       begin n_err++; $display("FAIL fetch_addr got %h want 4", a); end
    n_cmp++; if ({w, s} !== 5'b0_1111) begin n_err++; $display("FAIL fetch_we_sel got %b want 01111", {w, s}); end
    n_cmp++; if (aa !== 1'b0)       begin n_err++; $display("FAIL fetch_ack_width got %b want 0", aa); end
  endtask

  task automatic test_store_load();
    int at, nce, c; logic [31:0] rd, a; logic w, aa; logic [3:0] s; exp_t e;
    logic [31:0] adr [3]; logic [31:0] wd [3]; logic [3:0] sl [3]; logic wr [3]; logic [31:0] ex [3];
    adr = '{32'h100, 32'h100, 32'h100}; wr = '{1'b1, 1'b0, 1'b1};
    wd  = '{32'hDEAD_BEEF, 32'h0, 32'h0000_CAFE}; sl = '{4'hF, 4'hF, 4'h3};
    // store keeps the old load data (0 after reset), load sees the store
    ex  = '{32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    en1 = 1'b0; en3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        data_addr = adr[i]; data_we = wr[i]; data_wdata = wd[i]; data_sel = sl[i];
        sbq.push_back('{1'b1, ex[i], cyc + 4});
      end else begin
        data_addr = 32'h100; data_we = 1'b0; data_sel = 4'hF;
        sbq.push_back('{1'b1, 32'hDEAD_CAFE, cyc + 4});
      end
      data_req = 1'b1; c = cyc;
      run_until_ack(1'b1, 1'b1, at, rd, nce, a, w, s, aa);
      e = sbq.pop_front();
      n_cmp++; if (at !== e.ack_cyc) begin n_err++; $display("FAIL sl%0d_ack_cycle got %0d want %0d", i, at, e.ack_cyc); end
      n_cmp++; if (rd !== e.rdata)   begin n_err++; $display("FAIL sl%0d_rdata got %h want %h", i, rd, e.rdata); end
      n_cmp++; if (nce !== 3)        begin n_err++; $display("FAIL sl%0d_ce_cycles got %0d want 3", i, nce); end
      n_cmp++; if (aa !== 1'b0)      begin n_err++; $display("FAIL sl%0d_ack_width got %b want 0", i, aa); end
      if (i == 2) begin
        n_cmp++; if ({w, s} !== 5'b1_0011) begin n_err++; $display("FAIL sl2_we_sel got %b want 10011", {w, s}); end
      end
    end
  endtask

  task automatic test_contention();
    int c, got; exp_t e; logic exp_st;
    en1 = 1'b1; en3 = 1'b0;
    data_addr = 32'h100; data_we = 1'b0; data_sel = 4'hF; inst_addr = 32'h4;
    inst_req = 1'b1; data_req = 1'b1; c = cyc; got = 0;
    sbq.push_back('{1'b1, 32'hDEAD_CAFE, c + 2});
    sbq.push_back('{1'b0, 32'h3401_0100, c + 5});
    #1;
    n_cmp++; if (stall1 !== 1'b1) begin n_err++; $display("FAIL cont_stall_c0 got %b want 1", stall1); end
    for (int k = 0; k < 20 && got < 2; k++) begin
      @(negedge clk);
      exp_st = (cyc < c + 5);
      n_cmp++; if (stall1 !== exp_st) begin n_err++; $display("FAIL cont_stall_T+%0d got %b want %b", cyc - c, stall1, exp_st); end
      if (dack1 || iack1) begin
        got++;
        if (sbq.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL cont_unexpected_ack got ack at T+%0d want none", cyc - c);
        end else begin
          e = sbq.pop_front();
          n_cmp++; if (dack1 !== e.is_data) begin n_err++; $display("FAIL cont_owner got data=%b want data=%b", dack1, e.is_data); end
          n_cmp++; if (cyc !== e.ack_cyc)   begin n_err++; $display("FAIL cont_ack_cycle got T+%0d want T+%0d", cyc - c, e.ack_cyc - c); end
          n_cmp++; if ((dack1 ? drdata1 : irdata1) !== e.rdata) begin n_err++; $display("FAIL cont_rdata got %h want %h", dack1 ? drdata1 : irdata1, e.rdata); end
        end
        if (dack1) data_req = 1'b0;
        if (iack1) inst_req = 1'b0;
      end
    end
    n_cmp++; if (got !== 2) begin n_err++; $display("FAIL cont_grants got %0d want 2", got); end
    sbq.delete();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int c, got; exp_t e; bit ord [3];
`ifdef ARB_ROUND_ROBIN_EN
    ord = '{1'b1, 1'b0, 1'b1};
`else
    ord = '{1'b1, 1'b1, 1'b1};
`endif
    en1 = 1'b1; en3 = 1'b0;
    data_addr = 32'h100; data_we = 1'b0; inst_addr = 32'h4;
    inst_req = 1'b1; data_req = 1'b1; c = cyc; got = 0;
    for (int i = 0; i < 3; i++)
      sbq.push_back('{ord[i], ord[i] ? 32'hDEAD_CAFE : 32'h3401_0100, c + 2 + 3*i});
    for (int k = 0; k < 30 && got < 3; k++) begin
      @(negedge clk);
      if (dack1 || iack1) begin
        got++;
        e = sbq.pop_front();
        n_cmp++; if (dack1 !== e.is_data) begin n_err++; $display("FAIL b2b_grant%0d got data=%b want data=%b", got, dack1, e.is_data); end
        n_cmp++; if (cyc !== e.ack_cyc)   begin n_err++; $display("FAIL b2b_cycle%0d got T+%0d want T+%0d", got, cyc - c, e.ack_cyc - c); end
        // masters immediately replace their request; all drop after the third grant
        if (got == 3) begin inst_req = 1'b0; data_req = 1'b0; end
      end
    end
    n_cmp++; if (got !== 3) begin n_err++; $display("FAIL b2b_grants got %0d want 3", got); end
    sbq.delete(); inst_req = 1'b0; data_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    int at, nce, c; logic [31:0] rd, a; logic w, aa; logic [3:0] s; exp_t e;
    en1 = 1'b0; en3 = 1'b1;
    data_addr = 32'h100; data_we = 1'b0; data_sel = 4'hF; data_req = 1'b1; c = cyc;
    repeat (2) @(negedge clk);
    n_cmp++; if (ce3 !== 1'b1) begin n_err++; $display("FAIL mid_ce_before got %b want 1", ce3); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (ce3 !== 1'b0)   begin n_err++; $display("FAIL mid_ce_after_reset got %b want 0", ce3); end
    n_cmp++; if (dack3 !== 1'b0) begin n_err++; $display("FAIL mid_no_ack got %b want 0", dack3); end
    n_cmp++; if (drdata3 !== 32'h0) begin n_err++; $display("FAIL mid_rdata_cleared got %h want 0", drdata3); end
    rst = 1'b1;
    sbq.push_back('{1'b1, 32'hDEAD_CAFE, c + 7});
    run_until_ack(1'b1, 1'b1, at, rd, nce, a, w, s, aa);
    e = sbq.pop_front();
    n_cmp++; if (at !== e.ack_cyc) begin n_err++; $display("FAIL mid_reissue_cycle got %0d want %0d", at, e.ack_cyc); end
    n_cmp++; if (rd !== e.rdata)   begin n_err++; $display("FAIL mid_reissue_rdata got %h want %h", rd, e.rdata); end
    n_cmp++; if (nce !== 3)        begin n_err++; $display("FAIL mid_reissue_ce got %0d want 3", nce); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_load();
    test_contention();
    test_back_to_back();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
